// File: rtl/dataflow_distribute.sv
// Packet router with a two-entry skid buffer.
// Beats arrive on a single upstream valid/ready port and are steered to one of
// two destinations. The destination is chosen by `select` on a packet's first
// beat and then held for the rest of that packet. Downstream data and last are
// shared; only the per-destination valid bit differs. i_ready comes straight
// from a flop, so upstream sees no combinational path from downstream.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | between packets; the next accepted beat is routed by select
// S_LOCKED| inside a packet; beats follow lock_dest_q until i_last is seen

module dataflow_distribute #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [width-1:0] i_data,
   input  logic             i_last,
   input  logic             select,
   output logic [1:0]       o_valid,
   input  logic [1:0]       o_ready,
   output logic [width-1:0] o_data,
   output logic             o_last
);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic             lock_dest_q, lock_dest_d;

   logic             main_valid_q, main_valid_d;
   logic [width-1:0] main_data_q, main_data_d;
   logic             main_last_q, main_last_d;
   logic             main_dest_q, main_dest_d;

   logic             skid_valid_q, skid_valid_d;
   logic [width-1:0] skid_data_q, skid_data_d;
   logic             skid_last_q, skid_last_d;
   logic             skid_dest_q, skid_dest_d;

   logic             i_ready_q, i_ready_d;

   logic             accept;
   logic             consume;
   logic             beat_dest;

   assign accept    = i_valid & i_ready_q;
   assign consume   = main_valid_q & o_ready[main_dest_q];
   // Inside a packet, select is ignored in favour of the captured lock.
   assign beat_dest = (state_q == S_LOCKED) ? lock_dest_q : select;

   assign i_ready = i_ready_q;
   assign o_valid = {main_valid_q & main_dest_q, main_valid_q & ~main_dest_q};
   assign o_data  = main_data_q;
   assign o_last  = main_last_q;

   // Routing FSM: capture the destination on a packet's first beat.
   always_comb begin
      state_d     = state_q;
      lock_dest_d = lock_dest_q;
      if (accept) begin
         case (state_q)
            S_IDLE: begin
               if (!i_last) begin
                  state_d     = S_LOCKED;
                  lock_dest_d = select;
               end
            end
            S_LOCKED: begin
               if (i_last) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Buffer update: main drains to the output, skid catches one beat of stall.
   // An accepted beat implies the skid is empty, since i_ready mirrors it.
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_last_d  = main_last_q;
      main_dest_d  = main_dest_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_last_d  = skid_last_q;
      skid_dest_d  = skid_dest_q;

      if (consume) begin
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            main_last_d  = skid_last_q;
            main_dest_d  = skid_dest_q;
            skid_valid_d = 1'b0;
         end else begin
            main_valid_d = 1'b0;
         end
      end

      if (accept) begin
         if (!main_valid_q || consume) begin
            main_valid_d = 1'b1;
            main_data_d  = i_data;
            main_last_d  = i_last;
            main_dest_d  = beat_dest;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = i_data;
            skid_last_d  = i_last;
            skid_dest_d  = beat_dest;
         end
      end

      i_ready_d = ~skid_valid_d;
   end

   // State registers; reset empties both buffers and drops any lock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         lock_dest_q  <= 1'b0;
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_last_q  <= 1'b0;
         main_dest_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_last_q  <= 1'b0;
         skid_dest_q  <= 1'b0;
         i_ready_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         lock_dest_q  <= lock_dest_d;
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_last_q  <= main_last_d;
         main_dest_q  <= main_dest_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_last_q  <= skid_last_d;
         skid_dest_q  <= skid_dest_d;
         i_ready_q    <= i_ready_d;
      end
   end

endmodule

// File: tb/tb_dataflow_distribute.sv
// Directed bench for dataflow_distribute. Inputs change and outputs are sampled
// 1 time unit after each rising edge.

module tb_dataflow_distribute;

   logic       clk;
   logic       reset_n;
   logic       i_valid;
   logic       i_ready;
   logic [7:0] i_data;
   logic       i_last;
   logic       select;
   logic [1:0] o_valid;
   logic [1:0] o_ready;
   logic [7:0] o_data;
   logic       o_last;

   int vectors;
   int miscompares;

   dataflow_distribute #(.width(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .i_data  (i_data),
      .i_last  (i_last),
      .select  (select),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_data  (o_data),
      .o_last  (o_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic s);
      i_valid = v;
      i_data  = d;
      i_last  = l;
      select  = s;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      o_ready = 2'b11;
      drive(1'b1, 8'h99, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         vectors++;
         if (i_ready !== 1'b0 || o_valid !== 2'b00 || o_last !== 1'b0 || o_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_hold: i_ready=%b o_valid=%b o_last=%b o_data=%h, want 0 00 0 00",
                     i_ready, o_valid, o_last, o_data);
         end
      end
      reset_n = 1'b1;
      cyc();
      vectors++;
      if (i_ready !== 1'b1 || o_valid !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_release: i_ready=%b o_valid=%b, want 1 00", i_ready, o_valid);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      cyc();
   endtask

   task automatic test_single_beats();
      logic [1:0] exp_v [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
      o_ready = 2'b11;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'(i + 1), 1'b1, 1'(i % 2));
         cyc();
         vectors++;
         if (o_valid !== exp_v[i] || o_data !== 8'(i + 1) || o_last !== 1'b1 || i_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_beat[%0d]: o_valid=%b o_data=%h o_last=%b i_ready=%b, want %b %h 1 1",
                     i, o_valid, o_data, o_last, i_ready, exp_v[i], 8'(i + 1));
         end
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      cyc();
      vectors++;
      if (o_valid !== 2'b00) begin
         miscompares++;
         $display("FAIL single_drain: o_valid=%b, want 00", o_valid);
      end
   endtask

   task automatic test_packet();
      logic [7:0] d   [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
      logic       l   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic       s   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [1:0] ev  [6] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
      o_ready = 2'b11;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, d[i], l[i], s[i]);
         cyc();
         vectors++;
         if (o_valid !== ev[i] || o_data !== d[i] || o_last !== l[i]) begin
            miscompares++;
            $display("FAIL packet_beat[%0d]: o_valid=%b o_data=%h o_last=%b, want %b %h %b",
                     i, o_valid, o_data, o_last, ev[i], d[i], l[i]);
         end
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      cyc();
   endtask

   task automatic test_backpressure();
      o_ready = 2'b00;
      drive(1'b1, 8'h11, 1'b1, 1'b0);
      cyc();
      vectors++;
      if (i_ready !== 1'b1 || o_valid !== 2'b01 || o_data !== 8'h11) begin
         miscompares++;
         $display("FAIL bp_first: i_ready=%b o_valid=%b o_data=%h, want 1 01 11", i_ready, o_valid, o_data);
      end
      drive(1'b1, 8'h22, 1'b1, 1'b0);
      cyc();
      vectors++;
      if (i_ready !== 1'b0 || o_valid !== 2'b01 || o_data !== 8'h11) begin
         miscompares++;
         $display("FAIL bp_full: i_ready=%b o_valid=%b o_data=%h, want 0 01 11", i_ready, o_valid, o_data);
      end
      drive(1'b1, 8'h33, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         cyc();
         vectors++;
         if (i_ready !== 1'b0 || o_data !== 8'h11) begin
            miscompares++;
            $display("FAIL bp_stall[%0d]: i_ready=%b o_data=%h, want 0 11", i, i_ready, o_data);
         end
      end
      o_ready = 2'b11;
      cyc();
      vectors++;
      if (i_ready !== 1'b1 || o_valid !== 2'b01 || o_data !== 8'h22) begin
         miscompares++;
         $display("FAIL bp_drain1: i_ready=%b o_valid=%b o_data=%h, want 1 01 22", i_ready, o_valid, o_data);
      end
      cyc();
      vectors++;
      if (o_valid !== 2'b01 || o_data !== 8'h33) begin
         miscompares++;
         $display("FAIL bp_drain2: o_valid=%b o_data=%h, want 01 33", o_valid, o_data);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      cyc();
      vectors++;
      if (o_valid !== 2'b00 || i_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_empty: o_valid=%b i_ready=%b, want 00 1", o_valid, i_ready);
      end
   endtask

   task automatic test_hold();
      o_ready = 2'b10;
      drive(1'b1, 8'h5A, 1'b1, 1'b0);
      cyc();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (o_valid !== 2'b01 || o_data !== 8'h5A || o_last !== 1'b1) begin
            miscompares++;
            $display("FAIL hold[%0d]: o_valid=%b o_data=%h o_last=%b, want 01 5a 1",
                     i, o_valid, o_data, o_last);
         end
         cyc();
      end
      o_ready = 2'b01;
      cyc();
      vectors++;
      if (o_valid !== 2'b00) begin
         miscompares++;
         $display("FAIL hold_deliver: o_valid=%b, want 00", o_valid);
      end
   endtask

   task automatic test_reset_mid();
      o_ready = 2'b00;
      drive(1'b1, 8'h61, 1'b0, 1'b1);
      cyc();
      drive(1'b1, 8'h62, 1'b0, 1'b0);
      cyc();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      vectors++;
      if (o_valid !== 2'b10 || i_ready !== 1'b0 || o_data !== 8'h61) begin
         miscompares++;
         $display("FAIL mid_full: o_valid=%b i_ready=%b o_data=%h, want 10 0 61", o_valid, i_ready, o_data);
      end
      #2;
      reset_n = 1'b0;
      #1;
      vectors++;
      if (o_valid !== 2'b00 || i_ready !== 1'b0 || o_data !== 8'h00) begin
         miscompares++;
         $display("FAIL mid_async: o_valid=%b i_ready=%b o_data=%h, want 00 0 00", o_valid, i_ready, o_data);
      end
      cyc();
      reset_n = 1'b1;
      cyc();
      o_ready = 2'b11;
      drive(1'b1, 8'h71, 1'b1, 1'b0);
      cyc();
      vectors++;
      if (o_valid !== 2'b01 || o_data !== 8'h71) begin
         miscompares++;
         $display("FAIL mid_relock: o_valid=%b o_data=%h, want 01 71", o_valid, o_data);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      cyc();
      vectors++;
      if (o_valid !== 2'b00) begin
         miscompares++;
         $display("FAIL mid_dup: o_valid=%b, want 00", o_valid);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      o_ready     = 2'b00;
      i_valid     = 1'b0;
      i_data      = 8'h00;
      i_last      = 1'b0;
      select      = 1'b0;
      test_reset();
      test_single_beats();
      test_packet();
      test_backpressure();
      test_hold();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
